// File: rtl/brute_force_key_sequencer.sv
// Brute-force key search sequencer: steps candidate keys through init/shuffle/decode/verify stages.
// Optional per-stage wait timeout enabled by defining BF_STAGE_TIMEOUT_EN.
module brute_force_key_sequencer #(
  parameter int unsigned KEY_WIDTH      = 22,
  parameter int unsigned KEY_START      = 0,
  parameter int unsigned KEY_END        = 2**22 - 1,
  parameter int unsigned KEY_STEP       = 1,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 init_finish,
  input  logic                 shuffle_finish,
  input  logic                 decode_finish,
  input  logic                 verify_finish,
  input  logic                 verify_pass,
  output logic                 start_init,
  output logic                 start_shuffle,
  output logic                 start_decode,
  output logic                 start_verify,
  output logic [1:0]           select_share,
  output logic [KEY_WIDTH-1:0] key,
  output logic                 busy,
  output logic                 found,
  output logic                 exhausted,
  output logic                 timeout_err
);

  localparam int unsigned SUM_W = KEY_WIDTH + 1;

  if (KEY_STEP == 0 || TIMEOUT_CYCLES == 0) begin : g_bad_params
    $error("KEY_STEP and TIMEOUT_CYCLES must be nonzero");
  end

  typedef enum logic [3:0] {
    S_IDLE,
    S_START_INIT,
    S_WAIT_INIT,
    S_START_SHUFFLE,
    S_WAIT_SHUFFLE,
    S_START_DECODE,
    S_WAIT_DECODE,
    S_START_VERIFY,
    S_WAIT_VERIFY,
    S_NEXT_KEY,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [KEY_WIDTH-1:0] key_d;
  logic [SUM_W-1:0]     key_sum;
  logic                 found_d, exhausted_d, clr_flags, busy_now;
  logic                 start_init_d, start_shuffle_d, start_decode_d, start_verify_d;
  logic [1:0]           select_share_d;
  logic                 busy_d;

`ifdef BF_STAGE_TIMEOUT_EN
  localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               timeout_d;
`endif

  // Next-state, next-key, flag and registered-output computation
  always_comb begin
    state_d     = state_q;
    key_d       = key;
    found_d     = found;
    exhausted_d = exhausted;
    clr_flags   = 1'b0;
    busy_now    = !(state_q inside {S_IDLE, S_DONE});
    key_sum     = {1'b0, key} + SUM_W'(KEY_STEP);
`ifdef BF_STAGE_TIMEOUT_EN
    timeout_d   = timeout_err;
    timer_d     = '0;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_START_INIT;
          key_d     = KEY_WIDTH'(KEY_START);
          clr_flags = 1'b1;
        end
      end
      S_START_INIT:    state_d = S_WAIT_INIT;
      S_WAIT_INIT:     if (init_finish) state_d = S_START_SHUFFLE;
      S_START_SHUFFLE: state_d = S_WAIT_SHUFFLE;
      S_WAIT_SHUFFLE:  if (shuffle_finish) state_d = S_START_DECODE;
      S_START_DECODE:  state_d = S_WAIT_DECODE;
      S_WAIT_DECODE:   if (decode_finish) state_d = S_START_VERIFY;
      S_START_VERIFY:  state_d = S_WAIT_VERIFY;
      S_WAIT_VERIFY: begin
        if (verify_finish) begin
          if (verify_pass) begin
            state_d = S_DONE;
            found_d = 1'b1;
          end else begin
            state_d = S_NEXT_KEY;
          end
        end
      end
      S_NEXT_KEY: begin
        // Sum is one bit wider than the key, so overflow past KEY_END is always visible
        if (key_sum > SUM_W'(KEY_END)) begin
          state_d     = S_DONE;
          exhausted_d = 1'b1;
        end else begin
          key_d   = key_sum[KEY_WIDTH-1:0];
          state_d = S_START_INIT;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef BF_STAGE_TIMEOUT_EN
    // Counter restarts whenever a WAIT state is entered; a finish strobe beats the limit
    if ((state_q inside {S_WAIT_INIT, S_WAIT_SHUFFLE, S_WAIT_DECODE, S_WAIT_VERIFY}) &&
        (state_d == state_q)) begin
      if (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
        state_d   = S_DONE;
        timeout_d = 1'b1;
      end else begin
        timer_d = timer_q + TIMER_W'(1);
      end
    end
`endif

    if (abort && busy_now) begin
      state_d   = S_IDLE;
      key_d     = KEY_WIDTH'(KEY_START);
      clr_flags = 1'b1;
    end

    if (clr_flags) begin
      found_d     = 1'b0;
      exhausted_d = 1'b0;
`ifdef BF_STAGE_TIMEOUT_EN
      timeout_d   = 1'b0;
`endif
    end

    start_init_d    = (state_d == S_START_INIT);
    start_shuffle_d = (state_d == S_START_SHUFFLE);
    start_decode_d  = (state_d == S_START_DECODE);
    start_verify_d  = (state_d == S_START_VERIFY);
    busy_d          = !(state_d inside {S_IDLE, S_DONE});
    case (state_d)
      S_START_INIT, S_WAIT_INIT:       select_share_d = 2'd1;
      S_START_SHUFFLE, S_WAIT_SHUFFLE: select_share_d = 2'd2;
      S_START_DECODE, S_WAIT_DECODE,
      S_START_VERIFY, S_WAIT_VERIFY:   select_share_d = 2'd3;
      default:                         select_share_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      key           <= KEY_WIDTH'(KEY_START);
      found         <= 1'b0;
      exhausted     <= 1'b0;
      start_init    <= 1'b0;
      start_shuffle <= 1'b0;
      start_decode  <= 1'b0;
      start_verify  <= 1'b0;
      select_share  <= 2'd0;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      key           <= key_d;
      found         <= found_d;
      exhausted     <= exhausted_d;
      start_init    <= start_init_d;
      start_shuffle <= start_shuffle_d;
      start_decode  <= start_decode_d;
      start_verify  <= start_verify_d;
      select_share  <= select_share_d;
      busy          <= busy_d;
    end
  end

`ifdef BF_STAGE_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q     <= '0;
      timeout_err <= 1'b0;
    end else begin
      timer_q     <= timer_d;
      timeout_err <= timeout_d;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule
